// File: rtl/bs_rx_descrambler.sv
// Backscatter receive path: synchronises the comparator bit stream, finds the end of the
// all-zero preamble, descrambles the payload into bytes and reports per-packet status.
module bs_rx_descrambler #(
  parameter int          DATARATE_DIV = 100,
  parameter int          PRE_LEN      = 432,
  parameter int          TAIL_LEN     = 32,
  parameter int          PRE_MIN_BITS = 400,
  parameter int          TIMEOUT_CYC  = 100000,
  parameter logic [7:0]  PATTERN      = 8'hF0
) (
  input  logic        clki,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_in,
  input  logic [31:0] pkt_duration,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        busy,
  output logic        pkt_done,
  output logic        rx_timeout,
  output logic        len_err,
  output logic [15:0] err_count
);

  localparam int HALF    = DATARATE_DIV / 2;
  localparam int MIN_LOW = PRE_MIN_BITS * DATARATE_DIV;
  localparam int PW      = $clog2(DATARATE_DIV);
  localparam int LW      = $clog2(MIN_LOW + 1);
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
  localparam int KW      = $clog2(TAIL_LEN + 1);
  localparam logic [31:0] MIN_DUR   = 32'(PRE_LEN + TAIL_LEN + 8);
  localparam logic [31:0] FRAME_OVH = 32'(PRE_LEN + TAIL_LEN);

  typedef enum logic [1:0] {IDLE, HUNT, DATA, TAIL} state_t;

  state_t          state_reg;
  logic [2:0]      sync_reg;
  logic [PW-1:0]   phase_reg;
  logic [LW-1:0]   low_cnt_reg;
  logic [TW-1:0]   tmo_cnt_reg;
  logic [KW-1:0]   tail_cnt_reg;
  logic [31:0]     bit_cnt_reg;
  logic [31:0]     last_bit_reg;
  logic [7:0]      hist_reg;
  logic [6:0]      shift_reg;
  logic [2:0]      bit_idx_reg;

  logic       line;
  logic       edge_det;
  logic       rise;
  logic       phase_last;
  logic       sample_pt;
  logic       descr;
  logic [7:0] new_byte;

  // sync_reg[1:0] is the two-stage synchroniser, sync_reg[2] the edge-detect delay.
  assign line       = sync_reg[1];
  assign edge_det   = sync_reg[2] ^ sync_reg[1];
  assign rise       = ~sync_reg[2] & sync_reg[1];
  assign phase_last = (phase_reg == PW'(DATARATE_DIV - 1));
  assign sample_pt  = (phase_reg == PW'(HALF - 1));
  assign descr      = line ^ hist_reg[0] ^ hist_reg[3] ^ hist_reg[4] ^ hist_reg[6] ^ hist_reg[7];
  assign new_byte   = {shift_reg, descr};

  always_ff @(posedge clki) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sync_reg     <= '0;
      phase_reg    <= '0;
      low_cnt_reg  <= '0;
      tmo_cnt_reg  <= '0;
      tail_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      last_bit_reg <= '0;
      hist_reg     <= '0;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      byte_data    <= '0;
      byte_valid   <= 1'b0;
      busy         <= 1'b0;
      pkt_done     <= 1'b0;
      rx_timeout   <= 1'b0;
      len_err      <= 1'b0;
      err_count    <= '0;
    end else begin
      sync_reg   <= {sync_reg[1:0], rx_in};
      byte_valid <= 1'b0;
      pkt_done   <= 1'b0;
      rx_timeout <= 1'b0;
      len_err    <= 1'b0;
      phase_reg  <= phase_last ? '0 : phase_reg + PW'(1);

      case (state_reg)
        IDLE: begin
          if (start) begin
            if (pkt_duration < MIN_DUR) begin
              len_err <= 1'b1;
            end else begin
              last_bit_reg <= pkt_duration - FRAME_OVH - 32'd1;
              err_count    <= '0;
              tmo_cnt_reg  <= '0;
              low_cnt_reg  <= '0;
              busy         <= 1'b1;
              state_reg    <= HUNT;
            end
          end
        end

        HUNT: begin
          if (line)
            low_cnt_reg <= '0;
          else if (low_cnt_reg != LW'(MIN_LOW))
            low_cnt_reg <= low_cnt_reg + LW'(1);

          // A qualifying edge takes priority over an expiring timeout.
          if (rise && low_cnt_reg >= LW'(MIN_LOW)) begin
            state_reg   <= DATA;
            phase_reg   <= '0;
            hist_reg    <= '0;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
          end else if (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
            rx_timeout <= 1'b1;
            busy       <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
          end
        end

        DATA: begin
          if (edge_det) begin
            phase_reg <= '0;
          end else if (sample_pt) begin
            hist_reg    <= {hist_reg[6:0], line};
            shift_reg   <= new_byte[6:0];
            bit_idx_reg <= bit_idx_reg + 3'd1;
            bit_cnt_reg <= bit_cnt_reg + 32'd1;
            if (bit_idx_reg == 3'd7) begin
              byte_data  <= new_byte;
              byte_valid <= 1'b1;
              if (new_byte != PATTERN && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            end
            // A trailing partial byte is simply left in shift_reg.
            if (bit_cnt_reg == last_bit_reg) begin
              tail_cnt_reg <= '0;
              state_reg    <= TAIL;
            end
          end
        end

        TAIL: begin
          // First wrap closes the last payload period, then TAIL_LEN more periods.
          if (phase_last) begin
            if (tail_cnt_reg == KW'(TAIL_LEN)) begin
              pkt_done  <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              tail_cnt_reg <= tail_cnt_reg + KW'(1);
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_rx_descrambler.sv
// Scoreboard bench for bs_rx_descrambler: a scrambling transmitter model drives rx_in,
// expected strobes are queued at stimulus time and a monitor checks them as they appear.
module tb_bs_rx_descrambler;

  localparam int DIV  = 20;
  localparam int PRE  = 64;
  localparam int TAIL = 32;
  localparam int MINB = 40;
  localparam int TMO  = 2000;
  localparam logic [7:0] PAT = 8'hF0;

  localparam int K_BYTE = 0;
  localparam int K_DONE = 1;
  localparam int K_TMO  = 2;
  localparam int K_LEN  = 3;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_in = 1'b0;
  logic [31:0] pkt_duration = '0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        busy;
  logic        pkt_done;
  logic        rx_timeout;
  logic        len_err;
  logic [15:0] err_count;

  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  ev_t exp_q[$];
  logic pay [0:63];

  bs_rx_descrambler #(
    .DATARATE_DIV(DIV), .PRE_LEN(PRE), .TAIL_LEN(TAIL),
    .PRE_MIN_BITS(MINB), .TIMEOUT_CYC(TMO), .PATTERN(PAT)
  ) dut (
    .clki(clk), .rst_n(rst_n), .start(start), .rx_in(rx_in),
    .pkt_duration(pkt_duration), .byte_data(byte_data), .byte_valid(byte_valid),
    .busy(busy), .pkt_done(pkt_done), .rx_timeout(rx_timeout), .len_err(len_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_BYTE:  return "byte";
      K_DONE:  return "pkt_done_err_count";
      K_TMO:   return "rx_timeout_latency";
      default: return "len_err";
    endcase
  endfunction

  // Monitor: pops one expected event per observed strobe.
  initial begin : monitor
    forever begin
      int  nstb;
      ev_t got;
      ev_t want;
      @(negedge clk);
      nstb = int'(byte_valid) + int'(pkt_done) + int'(rx_timeout) + int'(len_err);
      if (nstb > 0) begin
        compared++;
        if (nstb > 1) begin
          mismatched++;
          $display("FAIL exclusive: %0d strobes high, required 1", nstb);
        end
        if (byte_valid)      got = '{K_BYTE, int'(byte_data)};
        else if (pkt_done)   got = '{K_DONE, int'(err_count)};
        else if (rx_timeout) got = '{K_TMO, cyc - start_cyc};
        else                 got = '{K_LEN, 0};
        $display("[%0d] %s 0x%0h", cyc, kname(got.kind), got.val);
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_%s: got 0x%0h, required no strobe", kname(got.kind), got.val);
        end else begin
          want = exp_q.pop_front();
          if (got.kind != want.kind || got.val != want.val) begin
            mismatched++;
            $display("FAIL %s: got %s 0x%0h, required %s 0x%0h", kname(want.kind),
                     kname(got.kind), got.val, kname(want.kind), want.val);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, want);
    end
  endtask

  task automatic expect_ev(input int kind, input int val);
    exp_q.push_back('{kind, val});
  endtask

  task automatic load(input logic [39:0] v, input int n);
    for (int i = 0; i < n; i++) pay[i] = v[39-i];
  endtask

  task automatic next_len(input bit jit, inout int drift, output int len);
    len = DIV;
    if (jit) begin
      len = DIV - 1 + int'($urandom_range(2, 0));
      if (drift + len - DIV > 2 || drift + len - DIV < -2) len = DIV;
    end
    drift += len - DIV;
  endtask

  task automatic tx_bit(input logic b, input int len);
    rx_in = b;
    repeat (len) @(negedge clk);
  endtask

  // Transmitter: zero preamble, self-synchronising scrambled payload, raw zero tail.
  task automatic send_packet(input int npay, input bit jit, input int glitch_bit, input int stop_bit);
    logic [7:0] s;
    logic       sb;
    int         drift;
    int         len;
    s = '0;
    drift = 0;
    for (int i = 0; i < PRE; i++) begin
      next_len(jit, drift, len);
      if (i == glitch_bit) begin
        rx_in = 1'b1;
        @(negedge clk);
        rx_in = 1'b0;
        repeat (len - 1) @(negedge clk);
      end else begin
        tx_bit(1'b0, len);
      end
    end
    for (int i = 0; i < npay; i++) begin
      if (i == stop_bit) return;
      sb = pay[i] ^ s[0] ^ s[3] ^ s[4] ^ s[6] ^ s[7];
      s = {s[6:0], sb};
      next_len(jit, drift, len);
      tx_bit(sb, len);
    end
    for (int i = 0; i < TAIL; i++) begin
      next_len(jit, drift, len);
      tx_bit(1'b0, len);
    end
  endtask

  task automatic do_start(input int dur);
    pkt_duration = 32'(dur);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expected events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic expect_nominal(input int done_err);
    for (int i = 0; i < 4; i++) expect_ev(K_BYTE, 8'hF0);
    expect_ev(K_DONE, done_err);
  endtask

  initial begin : driver
    repeat (4) @(negedge clk);
    check("reset_outputs", int'({byte_data, byte_valid, busy, pkt_done, rx_timeout, len_err, err_count}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Nominal packet: 32 payload bits of F0.
    load({32'hF0F0F0F0, 8'h00}, 32);
    expect_nominal(0);
    do_start(PRE + TAIL + 32);
    check("busy_after_start", int'(busy), 1);
    send_packet(32, 1'b0, -1, -1);
    drain(400);
    check("busy_after_done", int'(busy), 0);

    // Jittered bit lengths.
    expect_nominal(0);
    do_start(PRE + TAIL + 32);
    send_packet(32, 1'b1, -1, -1);
    drain(400);

    // One-cycle glitch early in the preamble.
    expect_nominal(0);
    do_start(PRE + TAIL + 32);
    send_packet(32, 1'b0, 10, -1);
    drain(400);

    // Length rejection, including the off-by-one boundary.
    expect_ev(K_LEN, 0);
    do_start(PRE + TAIL + 6);
    check("busy_len_err_short", int'(busy), 0);
    repeat (5) @(negedge clk);
    expect_ev(K_LEN, 0);
    do_start(PRE + TAIL + 7);
    check("busy_len_err_boundary", int'(busy), 0);
    drain(20);

    // Minimum accepted length: one byte.
    load({8'hF0, 32'h0}, 8);
    expect_ev(K_BYTE, 8'hF0);
    expect_ev(K_DONE, 0);
    do_start(PRE + TAIL + 8);
    check("busy_min_len", int'(busy), 1);
    send_packet(8, 1'b0, -1, -1);
    drain(400);

    // 36 payload bits, third byte corrupted, 4 leftover bits discarded.
    load({8'hF0, 8'hF0, 8'hF4, 8'hF0, 8'hF0}, 36);
    expect_ev(K_BYTE, 8'hF0);
    expect_ev(K_BYTE, 8'hF0);
    expect_ev(K_BYTE, 8'hF4);
    expect_ev(K_BYTE, 8'hF0);
    expect_ev(K_DONE, 1);
    do_start(PRE + TAIL + 36);
    send_packet(36, 1'b0, -1, -1);
    drain(400);
    repeat (20) @(negedge clk);
    check("err_count_hold", int'(err_count), 1);

    // Reset during the second byte.
    load({32'hF0F0F0F0, 8'h00}, 32);
    expect_ev(K_BYTE, 8'hF0);
    do_start(PRE + TAIL + 32);
    check("err_count_cleared", int'(err_count), 0);
    send_packet(32, 1'b0, -1, 12);
    rx_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_reset_outputs", int'({byte_data, byte_valid, busy, pkt_done, rx_timeout, len_err, err_count}), 0);
    repeat (40 * DIV) @(negedge clk);
    check("queue_after_abort", exp_q.size(), 0);
    expect_nominal(0);
    do_start(PRE + TAIL + 32);
    send_packet(32, 1'b0, -1, -1);
    drain(400);

    // No data edge: timeout exactly TMO cycles after start.
    expect_ev(K_TMO, TMO);
    do_start(PRE + TAIL + 32);
    rx_in = 1'b0;
    repeat (TMO + TMO / 5) @(negedge clk);
    check("busy_after_timeout", int'(busy), 0);
    drain(10);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
